// File: rtl/call_stack_pkg.sv
// Shared types for the call/return stack controller: FSM states and the reserved frame index.
package call_stack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_SETUP,
    S_POP,
    S_DONE
  } state_t;

  localparam int unsigned RSVD_FRAME = 0;

endpackage

// File: rtl/call_stack_pc_mem.sv
// Return-PC storage: DEPTH entries indexed 1..DEPTH, synchronous write and synchronous read.
module call_stack_pc_mem
  import call_stack_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 5,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [PC_WIDTH-1:0] i_waddr,
  input  logic [PC_WIDTH-1:0] i_wdata,
  input  logic                i_re,
  input  logic [PC_WIDTH-1:0] i_raddr,
  output logic [PC_WIDTH-1:0] o_rdata
);

  logic [PC_WIDTH-1:0] r_mem [1:DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != PC_WIDTH'(RSVD_FRAME))) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/RET sequencer: drives register-file stack strobes/pointer and keeps the return-PC stack.
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 5,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         call_req,
  input  logic [PC_WIDTH-1:0]          call_ret_pc,
  input  logic                         ret_req,
  input  logic                         clr_err,
  output logic                         rf_stack_push,
  output logic                         rf_stack_pop,
  output logic [PC_WIDTH-1:0]          rf_stack_pointer,
  output logic                         call_done,
  output logic                         ret_done,
  output logic [PC_WIDTH-1:0]          ret_pc,
  output logic                         busy,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  state_t              r_state;
  logic [DW-1:0]       r_depth;
  logic [PC_WIDTH-1:0] r_ptr;
  logic [PC_WIDTH-1:0] r_pc_lat;
  logic [PC_WIDTH-1:0] r_ret_pc;
  logic                r_push;
  logic                r_pop;
  logic                r_call_done;
  logic                r_ret_done;
  logic                r_ovf;
  logic                r_unf;

  logic [PC_WIDTH-1:0] w_depth_pc;
  logic [PC_WIDTH-1:0] w_depth_up;
  logic [PC_WIDTH-1:0] w_rd_data;
  logic                w_full;
  logic                w_empty;

  assign w_depth_pc = PC_WIDTH'(r_depth);
  assign w_depth_up = w_depth_pc + PC_WIDTH'(1);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);

  call_stack_pc_mem #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_pc_mem (
    .clk     (clk),
    .i_we    (r_state == S_PUSH),
    .i_waddr (w_depth_up),
    .i_wdata (r_pc_lat),
    .i_re    (r_state == S_POP_SETUP),
    .i_raddr (w_depth_pc),
    .o_rdata (w_rd_data)
  );

  // Pointer is registered, so each branch loads the value for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_depth     <= '0;
      r_ptr       <= PC_WIDTH'(RSVD_FRAME);
      r_pc_lat    <= '0;
      r_ret_pc    <= '0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_call_done <= 1'b0;
      r_ret_done  <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      // Clear first so a fault raised in the same cycle takes precedence.
      if (clr_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_ptr <= w_depth_up;
          if (call_req) begin
            if (!w_full) begin
              r_pc_lat <= call_ret_pc;
              r_push   <= 1'b1;
              r_state  <= S_PUSH;
            end else begin
              r_ovf       <= 1'b1;
              r_call_done <= 1'b1;
              r_state     <= S_DONE;
            end
          end else if (ret_req) begin
            if (!w_empty) begin
              r_ptr   <= w_depth_pc;
              r_state <= S_POP_SETUP;
            end else begin
              r_unf      <= 1'b1;
              r_ret_done <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_PUSH: begin
          r_push      <= 1'b0;
          r_depth     <= r_depth + DW'(1);
          r_ptr       <= w_depth_up + PC_WIDTH'(1);
          r_call_done <= 1'b1;
          r_state     <= S_DONE;
        end
        S_POP_SETUP: begin
          r_pop   <= 1'b1;
          r_ptr   <= w_depth_pc;
          r_state <= S_POP;
        end
        S_POP: begin
          r_pop      <= 1'b0;
          r_depth    <= r_depth - DW'(1);
          r_ptr      <= w_depth_pc;
          r_ret_pc   <= w_rd_data;
          r_ret_done <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_call_done <= 1'b0;
          r_ret_done  <= 1'b0;
          r_ptr       <= w_depth_up;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rf_stack_push    = r_push;
  assign rf_stack_pop     = r_pop;
  assign rf_stack_pointer = r_ptr;
  assign call_done        = r_call_done;
  assign ret_done         = r_ret_done;
  assign ret_pc           = r_ret_pc;
  assign busy             = (r_state != S_IDLE);
  assign overflow         = r_ovf;
  assign underflow        = r_unf;
  assign depth            = r_depth;

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
Controller that drives the register-file context stack and keeps the matching return-PC stack for CALL/RET instructions.
- Accepts call/return requests from the control unit over a req/done handshake.
- Sequences the register-file push/pop strobes and presents the stack pointer to the register file.
- Stores and returns the return PC for each frame.
- Flags overflow and underflow. On either fault it suppresses the strobe, so register-file contents are never corrupted.

Parameters:
PC_WIDTH, 5, width of program counter and of stack pointer output
DEPTH, 16, number of frames; legal range 1 to 2**PC_WIDTH-1 (frame index 0 is reserved)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
call_req  input  1  call request; held high until call_done
call_ret_pc  input  PC_WIDTH  return address to save; sampled in the accept cycle
ret_req  input  1  return request; held high until ret_done
clr_err  input  1  clears sticky error flags
rf_stack_push  output  1  one-cycle push strobe to register file
rf_stack_pop  output  1  one-cycle pop strobe to register file
rf_stack_pointer  output  PC_WIDTH  frame index presented to register-file stack
call_done  output  1  one-cycle completion pulse for call (also on overflow reject)
ret_done  output  1  one-cycle completion pulse for return (also on underflow reject)
ret_pc  output  PC_WIDTH  popped return PC, valid while ret_done is high
busy  output  1  high in any state other than IDLE
overflow  output  1  sticky: call attempted with stack full
underflow  output  1  sticky: return attempted with stack empty
depth  output  $clog2(DEPTH+1)  current number of saved frames

Behaviour:
- Reset (async, rst_n low): state=IDLE, depth=0, overflow=0, underflow=0, all strobes/done=0, ret_pc=0, rf_stack_pointer=0. PC memory contents are not cleared. Reset mid-operation abandons the operation with no done pulse.
- Frame indexing: frames occupy 1..DEPTH. The pointer driven during any pop is always >=1, as the register file requires.
- rf_stack_pointer: depth+1 in IDLE and PUSH; depth in POP_SETUP and POP.
- States: IDLE, PUSH, POP_SETUP, POP, DONE.
- IDLE, acceptance:
  - call_req has priority over ret_req. If both are high, the call is taken; ret_req stays pending.
  - call_req with depth<DEPTH: latch call_ret_pc, go to PUSH.
  - call_req with depth==DEPTH: set overflow, pulse call_done next cycle via DONE, no push.
  - ret_req with depth>0: go to POP_SETUP.
  - ret_req with depth==0: set underflow, pulse ret_done via DONE, no pop.
- PUSH (1 cycle):
  - rf_stack_push=1, pointer=depth+1.
  - PC memory written at index depth+1.
  - depth increments at the end of the cycle.
  - Next state DONE.
- POP_SETUP (1 cycle):
  - pointer=depth, strobes low. Gives synchronous-read stack memories one cycle of address setup.
  - PC memory read is issued.
  - Next state POP.
- POP (1 cycle):
  - rf_stack_pop=1, pointer=depth.
  - ret_pc registered from PC memory.
  - depth decrements at the end of the cycle.
  - Next state DONE.
- DONE (1 cycle): call_done or ret_done=1 matching the accepted request, busy=1. Next state IDLE.
  - The requester drops req on the done pulse.
  - A req still high in IDLE is treated as a new request.
- Latency, req rise to done: call 2 cycles, return 3 cycles, fault reject 1 cycle.
- Requests arriving while busy=1 are ignored, not queued.
- rf_stack_push and rf_stack_pop are never high in the same cycle and are each at most one cycle long per operation.
- clr_err clears both flags. If clr_err and a new fault occur in the same cycle, the set wins.
- depth never wraps: saturation at 0 and DEPTH is enforced by the fault paths.

Decomposition:
- Package call_stack_pkg: state enum (IDLE, PUSH, POP_SETUP, POP, DONE) and a constant for the reserved frame index 0.
- One sub-module, call_stack_pc_mem: DEPTH x PC_WIDTH, one synchronous write port, one synchronous read port, indexed 1..DEPTH.

Test Plan:
- Reset then call_req with call_ret_pc=5'h0A:
  - rf_stack_push high exactly one cycle with pointer=1.
  - call_done 2 cycles after req.
  - depth=1.
- Three calls (PCs 0x03, 0x07, 0x1C) then three returns:
  - ret_pc sequence 0x1C, 0x07, 0x03.
  - rf_stack_pop pointers 3, 2, 1.
  - depth ends at 0.
- ret_req at depth=0:
  - no pop strobe.
  - underflow=1, ret_done after 1 cycle.
  - clr_err clears underflow.
- DEPTH calls then one more:
  - the extra call produces no push strobe.
  - overflow=1, depth stays at DEPTH.
- call_req and ret_req raised together at depth=2: call executes first (push pointer=3), then return (pop pointer=3, ret_pc = just-saved PC).
- rst_n low during POP_SETUP: all outputs 0 immediately, no ret_done, depth=0 after release.
